rr_arbiter_8: RTL and testbench



---
 rtl/rr_arbiter_8_pkg.sv | 34 +++
 rtl/rr_arbiter_8_dec.sv | 13 +
 rtl/rr_arbiter_8.sv | 87 ++++++++
 tb/tb_rr_arbiter_8.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: widths, state codes, search helper.
// Combinational helpers only; no state.
// No flow control; the package holds types and functions only.
package rr_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of r visiting start, start+1, ... mod N_REQ.
    // Walks from the far end so that the nearest hit is written last.
    function automatic pick_t rr_search(input logic [N_REQ-1:0] r,
                                        input logic [IDX_W-1:0] start);
        pick_t            p;
        logic [IDX_W-1:0] k;
        p = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = start + IDX_W'(i);
            if (r[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_dec.sv
// 3-to-8 one-hot decoder shared across the codebase.
// Purely combinational, zero latency.
// No flow control.
module rr_arbiter_8_dec
    import rr_arbiter_8_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    assign onehot = N_REQ'(1) << idx;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a hold limit against starvation.
// Request sampled at edge N, registered grant visible right after edge N.
// No backpressure; a holder keeps the grant until it drops req or the hold limit forces rotation.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [N_REQ-1:0] others;
    logic [N_REQ-1:0] dec_onehot;
    pick_t            idle_pick;
    pick_t            grant_pick;

    // While granting, ptr equals the holder, so excluding the holder and
    // searching from holder+1 covers both release handoff and forced rotation.
    always_comb begin
        others            = req;
        others[grant_idx] = 1'b0;
        idle_pick         = rr_search(req, ptr + IDX_ONE);
        grant_pick        = rr_search(others, grant_idx + IDX_ONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= IDX_W'(N_REQ - 1);
            hold_cnt    <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick.found) begin
                        grant_idx   <= idle_pick.idx;
                        grant_valid <= 1'b1;
                        ptr         <= idle_pick.idx;
                        hold_cnt    <= '0;
                        state       <= GRANT;
                    end
                end
                default: begin
                    if (!req[grant_idx]) begin
                        if (grant_pick.found) begin
                            grant_idx <= grant_pick.idx;
                            ptr       <= grant_pick.idx;
                            hold_cnt  <= '0;
                        end else begin
                            grant_valid <= 1'b0;
                            hold_cnt    <= '0;
                            state       <= IDLE;
                        end
                    end else if (hold_cnt < HOLD_LAST) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end else if (grant_pick.found) begin
                        grant_idx <= grant_pick.idx;
                        ptr       <= grant_pick.idx;
                        hold_cnt  <= '0;
                    end
                    // Sole requester at the limit: keep the grant, counter saturates.
                end
            endcase
        end
    end

    rr_arbiter_8_dec u_dec (
        .idx    (grant_idx),
        .onehot (dec_onehot)
    );

    assign grant = dec_onehot & {N_REQ{grant_valid}};

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 (MAX_HOLD=8 main instance, MAX_HOLD=1 side instance).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Invariants on both instances are checked on every falling edge.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant,  grant1;
    logic [2:0] grant_idx, grant_idx1;
    logic       grant_valid, grant_valid1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(8), .CNT_W(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    rr_arbiter_8 #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant1),
        .grant_idx   (grant_idx1),
        .grant_valid (grant_valid1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 unit after an edge: pulse reset well clear of the next edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        checks++;
        assert ($onehot0(grant) && (grant_valid || grant == 8'h00) &&
                $onehot0(grant1) && (grant_valid1 || grant1 == 8'h00)) else begin
            errors++;
            $error("FAIL invariant observed=%0h/%0h expected=onehot0 gated by valid", grant, grant1);
        end
    end

    initial begin
        rst = 1'b1;
        req = 8'h00;
        step();
        step();

        // Reset holds outputs clear even with every requester active.
        req = 8'hFF;
        step();
        chk("rst_grant", 32'(grant), 32'h00);
        chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        rst = 1'b0;
        step();
        chk("first_idx", 32'(grant_idx), 32'h0);
        chk("first_grant", 32'(grant), 32'h01);

        // Single requester stays granted past the hold limit.
        do_reset();
        req = 8'h10;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("single_idx_%0d", c), 32'({grant_valid, grant_idx}), 32'h0C);
        end
        req = 8'h00;
        step();
        chk("single_drop_valid", 32'(grant_valid), 32'h0);
        chk("single_drop_grant", 32'(grant), 32'h00);
        req = 8'h01;
        step();
        chk("idle_regrant", 32'({grant_valid, grant_idx}), 32'h08);

        // Release handoff from 2 to 5 without an idle cycle.
        do_reset();
        req = 8'h04;
        step();
        chk("handoff_hold", 32'(grant_idx), 32'h2);
        req = 8'h21;
        step();
        chk("handoff_idx", 32'({grant_valid, grant_idx}), 32'h0D);
        chk("handoff_grant", 32'(grant), 32'h20);

        // Starvation guard: 0 and 7 alternate every 8 cycles.
        do_reset();
        req = 8'h81;
        for (int c = 0; c < 17; c++) begin
            step();
            chk($sformatf("starve_%0d", c), 32'(grant_idx), (c < 8) ? 32'h0 : (c < 16) ? 32'h7 : 32'h0);
        end

        // Full contention: 8-cycle slots on the main instance, 1-cycle slots with MAX_HOLD=1.
        do_reset();
        req = 8'hFF;
        for (int c = 0; c < 70; c++) begin
            step();
            chk($sformatf("full_idx_%0d", c), 32'(grant_idx), 32'((c / 8) % 8));
            chk($sformatf("full_grant_%0d", c), 32'(grant), 32'h1 << ((c / 8) % 8));
            chk($sformatf("mh1_idx_%0d", c), 32'({grant_valid1, grant_idx1}), 32'h8 | 32'(c % 8));
        end

        // Asynchronous reset between edges while 6 holds the grant.
        do_reset();
        req = 8'h40;
        step();
        chk("async_pre_idx", 32'(grant_idx), 32'h6);
        #2;
        rst = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'h00);
        chk("async_valid", 32'(grant_valid), 32'h0);
        chk("async_idx", 32'(grant_idx), 32'h0);
        rst = 1'b0;
        req = 8'h48;
        step();
        chk("post_async_idx", 32'({grant_valid, grant_idx}), 32'h0B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
